// File: rtl/dut_chk_pkg.sv
// Shared types and helpers for the stream checker: run-window states,
// the tolerance compare and a width helper that never returns zero.
package dut_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_e;

    // Widest sample the compare helper handles; samples are zero-extended to it.
    localparam int CHK_MAX_BW = 64;

    // $clog2 that yields at least 1, so single-entry selectors still get a bit.
    function automatic int chk_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // |rtl - lls| <= tol on zero-extended operands, using one extra bit so
    // the sign of the difference is never lost. tol == 0 is an exact compare.
    function automatic logic chk_match(input logic [CHK_MAX_BW-1:0] rtl,
                                       input logic [CHK_MAX_BW-1:0] lls,
                                       input logic [CHK_MAX_BW-1:0] tol);
        logic [CHK_MAX_BW:0] diff;
        logic [CHK_MAX_BW:0] mag;
        diff = {1'b0, rtl} - {1'b0, lls};
        mag  = diff[CHK_MAX_BW] ? (~diff + 1'b1) : diff;
        return mag <= {1'b0, tol};
    endfunction

endpackage

// File: rtl/dut_chk_fifo.sv
// Single-clock expected-sample FIFO with combinational head and a flush.
// A push while full is accepted only when a pop happens on the same edge.
module dut_chk_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices meet.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointers: flush empties the FIFO, otherwise advance on push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/dut_stream_checker.sv
// Multi-channel, latency-tolerant checker: expected (LLS) samples queue per
// channel and are compared in order against later RTL samples.
// Strobes are valid-only: there is no backpressure, so a sample presented with
// its strobe is consumed, compared, pushed, dropped or counted on that edge.
module dut_stream_checker
    import dut_chk_pkg::*;
#(
    parameter int BW_QUERY_DATA = 32,
    parameter int NUM_CH        = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int BW_CNT        = 16,
    parameter int TOL           = 0,
    parameter int DRAIN_TIMEOUT = 64,
    localparam int CH_W         = chk_width(NUM_CH)
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic                            iStart,
    input  logic                            iEnd,
    input  logic [NUM_CH-1:0]               iLlsValid,
    input  logic [NUM_CH*BW_QUERY_DATA-1:0] iLlsData,
    input  logic [NUM_CH-1:0]               iRtlValid,
    input  logic [NUM_CH*BW_QUERY_DATA-1:0] iRtlData,
    output logic                            oRun,
    output logic                            oDone,
    output logic                            oPass,
    output logic [NUM_CH*BW_CNT-1:0]        oPassCnt,
    output logic [NUM_CH*BW_CNT-1:0]        oFailCnt,
    output logic [NUM_CH-1:0]               oOverflow,
    output logic                            oFirstErrValid,
    output logic [CH_W-1:0]                 oFirstErrCh,
    output logic [BW_QUERY_DATA-1:0]        oFirstErrRtl,
    output logic [BW_QUERY_DATA-1:0]        oFirstErrLls,
    output logic [1:0]                      oDbgState
);
    localparam int BW   = BW_QUERY_DATA;
    localparam int DC_W = chk_width(DRAIN_TIMEOUT + 1);

    chk_state_e          state_q, state_d;
    logic [DC_W-1:0]     drain_cnt_q, drain_cnt_d;

    logic [NUM_CH-1:0]   empty, full;
    logic [BW-1:0]       head    [NUM_CH];
    logic [BW-1:0]       cmp_lls [NUM_CH];
    logic [NUM_CH-1:0]   pop, push, drop, byp, unf, matched, hit, miss;
    logic                rtl_act, lls_act, any_fail;
    logic [CH_W-1:0]     err_ch;
    logic [BW-1:0]       err_rtl, err_lls;

    logic [BW_CNT-1:0]   pass_cnt_q [NUM_CH];
    logic [BW_CNT-1:0]   fail_cnt_q [NUM_CH];
    logic [NUM_CH-1:0]   ovf_q;
    logic                ferr_v_q;
    logic [CH_W-1:0]     ferr_ch_q;
    logic [BW-1:0]       ferr_rtl_q, ferr_lls_q;

    // A start edge clears everything, so strobes on that cycle are discarded.
    assign rtl_act = ((state_q == RUN) || (state_q == DRAIN)) && !iStart;
    assign lls_act = (state_q == RUN) && !iStart;

    // Run-window FSM: start always (re)opens RUN; drain ends on empty or timeout.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        if (iStart) begin
            state_d     = RUN;
            drain_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    if (iEnd) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                DRAIN: begin
                    if ((&empty) || (drain_cnt_q >= DC_W'(DRAIN_TIMEOUT - 1))) begin
                        state_d = DONE;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DC_W'(1);
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and drain counter registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Per-channel pop/bypass/underflow/push decisions and the compare itself.
    always_comb begin
        pop = '0; push = '0; drop = '0; byp = '0; unf = '0;
        matched = '0; hit = '0; miss = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pop[k]     = rtl_act && iRtlValid[k] && !empty[k];
            byp[k]     = rtl_act && iRtlValid[k] && empty[k] && lls_act && iLlsValid[k];
            unf[k]     = rtl_act && iRtlValid[k] && empty[k] && !(lls_act && iLlsValid[k]);
            cmp_lls[k] = pop[k] ? head[k] : (byp[k] ? iLlsData[k*BW +: BW] : '0);
            matched[k] = chk_match(CHK_MAX_BW'(iRtlData[k*BW +: BW]),
                                   CHK_MAX_BW'(cmp_lls[k]), CHK_MAX_BW'(TOL));
            hit[k]     = (pop[k] || byp[k]) && matched[k];
            miss[k]    = ((pop[k] || byp[k]) && !matched[k]) || unf[k];
            push[k]    = lls_act && iLlsValid[k] && !byp[k] && (!full[k] || pop[k]);
            drop[k]    = lls_act && iLlsValid[k] && !byp[k] && full[k] && !pop[k];
        end
    end

    // Lowest-index erroring channel wins: scan downwards so it is assigned last.
    always_comb begin
        err_ch  = '0;
        err_rtl = '0;
        err_lls = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (miss[k]) begin
                err_ch  = CH_W'(k);
                err_rtl = iRtlData[k*BW +: BW];
                err_lls = cmp_lls[k];
            end
        end
    end

    // Saturating counters, sticky overflow and one-shot first-error capture.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst || iStart) begin
            for (int k = 0; k < NUM_CH; k++) begin
                pass_cnt_q[k] <= '0;
                fail_cnt_q[k] <= '0;
            end
            ovf_q      <= '0;
            ferr_v_q   <= 1'b0;
            ferr_ch_q  <= '0;
            ferr_rtl_q <= '0;
            ferr_lls_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (hit[k] && (pass_cnt_q[k] != '1)) pass_cnt_q[k] <= pass_cnt_q[k] + BW_CNT'(1);
                if (miss[k] && (fail_cnt_q[k] != '1)) fail_cnt_q[k] <= fail_cnt_q[k] + BW_CNT'(1);
                if (drop[k]) ovf_q[k] <= 1'b1;
            end
            if (!ferr_v_q && (|miss)) begin
                ferr_v_q   <= 1'b1;
                ferr_ch_q  <= err_ch;
                ferr_rtl_q <= err_rtl;
                ferr_lls_q <= err_lls;
            end
        end
    end

    // Any channel with a non-zero failure count spoils the verdict.
    always_comb begin
        any_fail = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (fail_cnt_q[k] != '0) any_fail = 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        dut_chk_fifo #(
            .W     (BW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (iClk),
            .rst_i   (iRst),
            .flush_i (iStart),
            .push_i  (push[k]),
            .data_i  (iLlsData[k*BW +: BW]),
            .pop_i   (pop[k]),
            .head_o  (head[k]),
            .full_o  (full[k]),
            .empty_o (empty[k])
        );
        assign oPassCnt[k*BW_CNT +: BW_CNT] = pass_cnt_q[k];
        assign oFailCnt[k*BW_CNT +: BW_CNT] = fail_cnt_q[k];
    end

    // Nothing moves once DONE, so residue seen now equals residue at DONE entry.
    assign oPass          = (state_q == DONE) && !any_fail && (ovf_q == '0) && (&empty);
    assign oRun           = (state_q == RUN) || (state_q == DRAIN);
    assign oDone          = (state_q == DONE);
    assign oOverflow      = ovf_q;
    assign oFirstErrValid = ferr_v_q;
    assign oFirstErrCh    = ferr_ch_q;
    assign oFirstErrRtl   = ferr_rtl_q;
    assign oFirstErrLls   = ferr_lls_q;
    assign oDbgState      = state_q;

endmodule

// File: tb/tb_dut_stream_checker.sv
// Directed bench for dut_stream_checker: a vector table for the basic
// latency/mismatch flow plus hand sequences for the multi-cycle corners.
module tb_dut_stream_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_end;
  logic [3:0]  i_lv, i_rv;
  logic [127:0] i_ld, i_rd;

  logic        run, done, pass, fev;
  logic [63:0] pc, fc;
  logic [3:0]  ovf;
  logic [1:0]  fech, dbg;
  logic [31:0] frtl, flls;

  logic        t_run, t_done, t_pass, t_fev;
  logic [63:0] t_pc, t_fc;
  logic [3:0]  t_ovf;
  logic [1:0]  t_fech, t_dbg;
  logic [31:0] t_frtl, t_flls;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  dut_stream_checker #(
    .BW_QUERY_DATA(32), .NUM_CH(4), .FIFO_DEPTH(8), .BW_CNT(16), .TOL(0), .DRAIN_TIMEOUT(64)
  ) u_dut (
    .iClk(clk), .iRst(rst), .iStart(i_start), .iEnd(i_end),
    .iLlsValid(i_lv), .iLlsData(i_ld), .iRtlValid(i_rv), .iRtlData(i_rd),
    .oRun(run), .oDone(done), .oPass(pass), .oPassCnt(pc), .oFailCnt(fc),
    .oOverflow(ovf), .oFirstErrValid(fev), .oFirstErrCh(fech),
    .oFirstErrRtl(frtl), .oFirstErrLls(flls), .oDbgState(dbg)
  );

  dut_stream_checker #(
    .BW_QUERY_DATA(32), .NUM_CH(4), .FIFO_DEPTH(8), .BW_CNT(16), .TOL(2), .DRAIN_TIMEOUT(64)
  ) u_tol (
    .iClk(clk), .iRst(rst), .iStart(i_start), .iEnd(i_end),
    .iLlsValid(i_lv), .iLlsData(i_ld), .iRtlValid(i_rv), .iRtlData(i_rd),
    .oRun(t_run), .oDone(t_done), .oPass(t_pass), .oPassCnt(t_pc), .oFailCnt(t_fc),
    .oOverflow(t_ovf), .oFirstErrValid(t_fev), .oFirstErrCh(t_fech),
    .oFirstErrRtl(t_frtl), .oFirstErrLls(t_flls), .oDbgState(t_dbg)
  );

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
  task automatic drive(input logic s, input logic e, input logic [3:0] lv, input logic [31:0] ld,
                       input logic [3:0] rv, input logic [31:0] rd);
    @(negedge clk);
    i_start = s; i_end = e;
    i_lv = lv; i_ld = {4{ld}};
    i_rv = rv; i_rd = {4{rd}};
    @(posedge clk);
    #1;
    i_start = 1'b0; i_end = 1'b0; i_lv = '0; i_rv = '0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
  endtask

  typedef struct {
    logic        start, stop;
    logic [3:0]  lv;
    logic [31:0] ld;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic        e_run, e_done, e_pass;
    logic [63:0] e_pc, e_fc;
    logic        e_fev;
    logic [1:0]  e_fech;
    logic [31:0] e_frtl, e_flls;
  } vec_t;

  vec_t vecs[15];

  localparam logic [63:0] FC_CH2 = 64'h0000_0001_0000_0000;

  initial begin
    int cyc;

    // Latency-aligned stream on ch0, then a mismatch on ch2.
    //                 st    en    lv    ld      rv    rd     run   done  pass  pc     fc      fev   ch    rtl    lls
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 32'd0,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'h1, 32'd10, 4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'h1, 32'd20, 4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, 1'b0, 4'h1, 32'd30, 4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h1, 32'd10, 1'b1, 1'b0, 1'b0, 64'd1, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h1, 32'd20, 1'b1, 1'b0, 1'b0, 64'd2, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h1, 32'd30, 1'b1, 1'b0, 1'b0, 64'd3, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 32'd0,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd3, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h0, 32'd0,  1'b0, 1'b1, 1'b1, 64'd3, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[10] = '{1'b1, 1'b0, 4'h0, 32'd0,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[11] = '{1'b0, 1'b0, 4'h4, 32'd5,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, 64'd0,  1'b0, 2'd0, 32'd0, 32'd0};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h4, 32'd7,  1'b1, 1'b0, 1'b0, 64'd0, FC_CH2, 1'b1, 2'd2, 32'd7, 32'd5};
    vecs[13] = '{1'b0, 1'b1, 4'h0, 32'd0,  4'h0, 32'd0,  1'b1, 1'b0, 1'b0, 64'd0, FC_CH2, 1'b1, 2'd2, 32'd7, 32'd5};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 32'd0,  4'h0, 32'd0,  1'b0, 1'b1, 1'b0, 64'd0, FC_CH2, 1'b1, 2'd2, 32'd7, 32'd5};

    i_start = 1'b0; i_end = 1'b0; i_lv = '0; i_rv = '0; i_ld = '0; i_rd = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_run", run, 0);   chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_pc", pc, 0);     chk("rst_fc", fc, 0);     chk("rst_ovf", ovf, 0);
    chk("rst_fev", fev, 0);   chk("rst_state", dbg, 0);

    // iEnd and strobes in IDLE do nothing.
    drive(1'b0, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    chk("idle_end_run", run, 0); chk("idle_end_state", dbg, 0);
    drive(1'b0, 1'b0, 4'h1, 32'd5, 4'h1, 32'd6);
    chk("idle_strobe_fc", fc, 0); chk("idle_strobe_pc", pc, 0);

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].lv, vecs[i].ld, vecs[i].rv, vecs[i].rd);
      chk($sformatf("v%0d_run", i),  run,  vecs[i].e_run);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_pass", i), pass, vecs[i].e_pass);
      chk($sformatf("v%0d_pc", i),   pc,   vecs[i].e_pc);
      chk($sformatf("v%0d_fc", i),   fc,   vecs[i].e_fc);
      chk($sformatf("v%0d_fev", i),  fev,  vecs[i].e_fev);
      chk($sformatf("v%0d_fech", i), fech, vecs[i].e_fech);
      chk($sformatf("v%0d_frtl", i), frtl, vecs[i].e_frtl);
      chk($sformatf("v%0d_flls", i), flls, vecs[i].e_flls);
    end

    // ---------------- tolerance (u_tol has TOL=2, u_dut exact) ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h1, 32'd100, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd102);
    chk("tol_102_pc", t_pc, 64'd1); chk("tol_102_fc", t_fc, 64'd0);
    chk("exact_102_fc", fc, 64'd1);
    drive(1'b0, 1'b0, 4'h1, 32'd100, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd98);
    chk("tol_98_pc", t_pc, 64'd2); chk("tol_98_fc", t_fc, 64'd0);
    drive(1'b0, 1'b0, 4'h1, 32'd100, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd103);
    chk("tol_103_fc", t_fc, 64'd1); chk("tol_103_pc", t_pc, 64'd2);
    chk("tol_103_frtl", t_frtl, 32'd103); chk("tol_103_flls", t_flls, 32'd100);
    chk("exact_fc", fc, 64'd3);

    // ---------------- full FIFO: push+pop, overflow, underflow ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 4'h1, i, 4'h0, 32'd0);
    chk("full8_ovf", ovf, 4'h0);
    drive(1'b0, 1'b0, 4'h1, 32'd8, 4'h1, 32'd0);
    chk("fullpp_ovf", ovf, 4'h0); chk("fullpp_pc", pc, 64'd1);
    drive(1'b0, 1'b0, 4'h1, 32'd9, 4'h0, 32'd0);
    chk("ovf_set", ovf, 4'h1);
    for (int i = 1; i <= 8; i++) drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, i);
    chk("drainpops_pc", pc, 64'd9); chk("drainpops_fc", fc, 64'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd9);
    chk("dropped_unf_fc", fc, 64'd1); chk("dropped_unf_flls", flls, 32'd0);
    chk("dropped_unf_frtl", frtl, 32'd9);
    drive(1'b0, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    idle();
    chk("ovf_done", done, 1); chk("ovf_pass", pass, 0);

    // ---------------- underflow + first-error priority ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    chk("restart_ovf_clr", ovf, 4'h0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'hA, 32'd55);
    chk("unf_fc", fc, 64'h0001_0000_0001_0000); chk("unf_fev", fev, 1);
    chk("unf_fech", fech, 2'd1); chk("unf_frtl", frtl, 32'd55); chk("unf_flls", flls, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd78);
    chk("ferr_sticky_ch", fech, 2'd1); chk("ferr_sticky_rtl", frtl, 32'd55);
    chk("unf2_fc", fc, 64'h0001_0000_0001_0001);

    // ---------------- drain timeout with residue ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b0, 4'h8, i, 4'h0, 32'd0);
    drive(1'b0, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    chk("drain_run", run, 1); chk("drain_state", dbg, 2'd2);
    cyc = 0;
    while (!done && cyc < 200) begin
      idle();
      cyc++;
    end
    chk("drain_cycles", cyc, 64); chk("timeout_done", done, 1); chk("timeout_pass", pass, 0);

    // ---------------- bypass on empty FIFO ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h1, 32'd9, 4'h1, 32'd9);
    chk("byp_pc", pc, 64'd1); chk("byp_fc", fc, 64'd0);
    drive(1'b0, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    idle();
    chk("byp_done", done, 1); chk("byp_pass", pass, 1);

    // ---------------- async reset mid-run ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd3);
    drive(1'b0, 1'b0, 4'h1, 32'd4, 4'h0, 32'd0);
    chk("pre_rst_fc", fc, 64'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_run", run, 0); chk("arst_fc", fc, 0); chk("arst_fev", fev, 0);
    chk("arst_frtl", frtl, 0); chk("arst_state", dbg, 0); chk("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    idle();
    chk("post_rst_pass", pass, 1);

    // ---------------- iStart and iEnd together ----------------
    drive(1'b1, 1'b0, 4'h0, 32'd0, 4'h0, 32'd0);
    drive(1'b0, 1'b0, 4'h0, 32'd0, 4'h1, 32'd3);
    chk("se_pre_fc", fc, 64'd1);
    drive(1'b1, 1'b1, 4'h0, 32'd0, 4'h0, 32'd0);
    chk("se_state", dbg, 2'd1); chk("se_fc", fc, 0); chk("se_fev", fev, 0);
    idle();
    chk("se_state_hold", dbg, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
